// File: rtl/ad9228_trig_capture.sv
// Triggered multi-channel capture: circular frame RAM, pre/post-trigger record, channel-interleaved readout.
// Read latency 1 cycle; no backpressure on frames, rd_en is accepted every cycle while the record is readable.
module ad9228_trig_capture #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 2048,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         sample_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] sample_data,
    input  logic                         arm,
    input  logic                         sw_trig,
    input  logic [1:0]                   trig_mode,
    input  logic [CH_W-1:0]              trig_ch,
    input  logic [DATA_WIDTH-1:0]        trig_level,
    input  logic [ADDR_W-1:0]            pre_samples,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic [CH_W-1:0]              rd_ch,
    output logic                         rd_last,
    output logic                         busy,
    output logic                         triggered,
    output logic                         done,
    output logic [ADDR_W-1:0]            trig_addr
);
    localparam int FW = NUM_CH * DATA_WIDTH;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       fill_cnt_q, fill_cnt_d;
    logic [ADDR_W:0]         post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0]       pre_q, pre_d;
    logic [1:0]              mode_q, mode_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [DATA_WIDTH-1:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0]   prev_q, prev_d;
    logic                    prev_vld_q, prev_vld_d;
    logic                    sw_pend_q, sw_pend_d;
    logic [ADDR_W-1:0]       trig_addr_q, trig_addr_d;
    logic                    triggered_q, triggered_d;
    logic [ADDR_W-1:0]       rd_frame_q, rd_frame_d;
    logic [CH_W-1:0]         rd_chn_q, rd_chn_d;
    logic                    rd_end_q, rd_end_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [CH_W-1:0]         rd_ch_q, rd_ch_d;
    logic                    rd_last_q, rd_last_d;

    logic [FW-1:0]           ram_q [DEPTH];

    logic                    wr_en, rd_acc, edge_hit, word_last;
    logic [CH_W-1:0]         cur_ch;
    logic [DATA_WIDTH-1:0]   cur_smp;
    logic [ADDR_W:0]         post_tgt;
    logic [ADDR_W-1:0]       rd_addr;

    function automatic logic [CH_W-1:0] ch_clamp(input logic [CH_W-1:0] c);
        return (int'(c) < NUM_CH) ? c : '0;
    endfunction

    always_comb begin
        // The arm cycle's own frame is compared on the newly requested channel.
        cur_ch    = arm ? ch_clamp(trig_ch) : ch_q;
        cur_smp   = sample_data[cur_ch*DATA_WIDTH +: DATA_WIDTH];
        wr_en     = sample_valid && (arm || (state_q inside {S_FILL, S_ARMED, S_POST}));
        edge_hit  = prev_vld_q &&
                    (((mode_q == 2'd1) && (prev_q < level_q) && (cur_smp >= level_q)) ||
                     ((mode_q == 2'd2) && (prev_q > level_q) && (cur_smp <= level_q)));
        post_tgt  = DEPTH_L - {1'b0, pre_q};
        rd_acc    = rd_en && !arm && (state_q == S_DONE) && !rd_end_q;
        rd_addr   = trig_addr_q - pre_q + rd_frame_q;
        word_last = (rd_frame_q == ADDR_W'(DEPTH - 1)) && (rd_chn_q == CH_W'(NUM_CH - 1));

        state_d     = state_q;
        wr_ptr_d    = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        post_cnt_d  = post_cnt_q;
        pre_d       = pre_q;
        mode_d      = mode_q;
        ch_d        = ch_q;
        level_d     = level_q;
        prev_d      = wr_en ? cur_smp : prev_q;
        prev_vld_d  = prev_vld_q || wr_en;
        sw_pend_d   = sw_pend_q;
        trig_addr_d = trig_addr_q;
        triggered_d = triggered_q;
        rd_frame_d  = rd_frame_q;
        rd_chn_d    = rd_chn_q;
        rd_end_d    = rd_end_q;
        rd_valid_d  = rd_acc;
        rd_last_d   = rd_acc && word_last;
        rd_data_d   = rd_acc ? ram_q[rd_addr][rd_chn_q*DATA_WIDTH +: DATA_WIDTH] : rd_data_q;
        rd_ch_d     = rd_acc ? rd_chn_q : rd_ch_q;

        if (arm) begin
            mode_d      = (trig_mode == 2'd3) ? 2'd0 : trig_mode;
            ch_d        = ch_clamp(trig_ch);
            level_d     = trig_level;
            pre_d       = pre_samples;
            prev_vld_d  = sample_valid;
            sw_pend_d   = 1'b0;
            triggered_d = 1'b0;
            rd_frame_d  = '0;
            rd_chn_d    = '0;
            rd_end_d    = 1'b0;
            fill_cnt_d  = sample_valid ? ADDR_W'(1) : '0;
            if ((pre_samples == '0) || (sample_valid && (pre_samples == ADDR_W'(1))))
                state_d = S_ARMED;
            else
                state_d = S_FILL;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (sample_valid) begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                        if (ADDR_W'(fill_cnt_q + 1'b1) == pre_q) state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (sample_valid && (sw_pend_q || sw_trig || edge_hit)) begin
                        trig_addr_d = wr_ptr_q;
                        triggered_d = 1'b1;
                        sw_pend_d   = 1'b0;
                        post_cnt_d  = (ADDR_W + 1)'(1);
                        state_d     = (post_tgt == (ADDR_W + 1)'(1)) ? S_DONE : S_POST;
                    end else if (sw_trig) begin
                        sw_pend_d = 1'b1;
                    end
                end
                S_POST: begin
                    if (sample_valid) begin
                        post_cnt_d = post_cnt_q + 1'b1;
                        if ((ADDR_W + 1)'(post_cnt_q + 1'b1) == post_tgt) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (rd_acc) begin
                        if (rd_chn_q == CH_W'(NUM_CH - 1)) begin
                            rd_chn_d   = '0;
                            rd_frame_d = rd_frame_q + 1'b1;
                        end else begin
                            rd_chn_d = rd_chn_q + 1'b1;
                        end
                        rd_end_d = word_last;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ram_q[wr_ptr_q] <= sample_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            post_cnt_q  <= '0;
            pre_q       <= '0;
            mode_q      <= '0;
            ch_q        <= '0;
            level_q     <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            sw_pend_q   <= 1'b0;
            trig_addr_q <= '0;
            triggered_q <= 1'b0;
            rd_frame_q  <= '0;
            rd_chn_q    <= '0;
            rd_end_q    <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_ch_q     <= '0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            post_cnt_q  <= post_cnt_d;
            pre_q       <= pre_d;
            mode_q      <= mode_d;
            ch_q        <= ch_d;
            level_q     <= level_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            sw_pend_q   <= sw_pend_d;
            trig_addr_q <= trig_addr_d;
            triggered_q <= triggered_d;
            rd_frame_q  <= rd_frame_d;
            rd_chn_q    <= rd_chn_d;
            rd_end_q    <= rd_end_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_ch_q     <= rd_ch_d;
            rd_last_q   <= rd_last_d;
        end
    end

    assign busy      = state_q inside {S_FILL, S_ARMED, S_POST};
    assign done      = (state_q == S_DONE);
    assign triggered = triggered_q;
    assign trig_addr = trig_addr_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_ch     = rd_ch_q;
    assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_ad9228_trig_capture.sv
// Bench for ad9228_trig_capture: NUM_CH=4, DEPTH=16; readout checked against a log of sent frames.
module tb_ad9228_trig_capture;
    localparam int NUM_CH = 4;
    localparam int DW     = 12;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int CW     = 2;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 sample_valid = 1'b0;
    logic [NUM_CH*DW-1:0] sample_data = '0;
    logic                 arm = 1'b0;
    logic                 sw_trig = 1'b0;
    logic [1:0]           trig_mode = '0;
    logic [CW-1:0]        trig_ch = '0;
    logic [DW-1:0]        trig_level = '0;
    logic [AW-1:0]        pre_samples = '0;
    logic                 rd_en = 1'b0;
    logic [DW-1:0]        rd_data;
    logic                 rd_valid;
    logic [CW-1:0]        rd_ch;
    logic                 rd_last;
    logic                 busy, triggered, done;
    logic [AW-1:0]        trig_addr;

    always #5 clk = ~clk;

    ad9228_trig_capture #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .sample_valid(sample_valid), .sample_data(sample_data),
        .arm(arm), .sw_trig(sw_trig), .trig_mode(trig_mode), .trig_ch(trig_ch),
        .trig_level(trig_level), .pre_samples(pre_samples), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_last(rd_last),
        .busy(busy), .triggered(triggered), .done(done), .trig_addr(trig_addr)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] ch;
        logic          last;
    } exp_t;

    int                   nchk = 0;
    int                   nerr = 0;
    int                   gidx = 0;
    logic [NUM_CH*DW-1:0] flog [0:127];
    exp_t                 exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_CH*DW-1:0] ramp(input int f);
        logic [NUM_CH*DW-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*DW +: DW] = DW'(16 * f + c);
        return v;
    endfunction

    function automatic logic [NUM_CH*DW-1:0] mkf(input logic [DW-1:0] ch2, input logic [DW-1:0] oth);
        return {oth, ch2, oth, oth};
    endfunction

    task automatic send(input logic [NUM_CH*DW-1:0] d, input logic swt, input logic logged);
        sample_valid = 1'b1; sample_data = d; sw_trig = swt;
        tick();
        sample_valid = 1'b0; sw_trig = 1'b0;
        if (logged) begin
            flog[gidx] = d;
            gidx++;
        end
    endtask

    task automatic do_arm(input logic [AW-1:0] p, input logic [1:0] m, input logic [CW-1:0] ch,
                          input logic [DW-1:0] lvl);
        arm = 1'b1; pre_samples = p; trig_mode = m; trig_ch = ch; trig_level = lvl;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0; sample_valid = 1'b0; arm = 1'b0; sw_trig = 1'b0; rd_en = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        gidx = 0;
    endtask

    // Reads n words of the record whose trigger frame is log index t with p pre-trigger frames.
    task automatic read_record(input string nm, input int t, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e, o;
            int   g;
            g      = t - p + k / NUM_CH;
            e.d    = flog[g][(k % NUM_CH)*DW +: DW];
            e.ch   = CW'(k % NUM_CH);
            e.last = (k == NUM_CH * DEPTH - 1);
            exp_q.push_back(e);
            rd_en = 1'b1;
            tick();
            o = exp_q.pop_front();
            nchk++;
            if (rd_valid !== 1'b1 || rd_data !== o.d || rd_ch !== o.ch || rd_last !== o.last) begin
                nerr++;
                $display("FAIL %s word %0d: got vld=%0b data=%h ch=%0d last=%0b want vld=1 data=%h ch=%0d last=%0b",
                         nm, k, rd_valid, rd_data, rd_ch, rd_last, o.d, o.ch, o.last);
            end
        end
        rd_en = 1'b0;
        tick();
        nchk++;
        if (rd_valid !== 1'b0) begin nerr++; $display("FAIL %s idle rd_valid: got %0b want 0", nm, rd_valid); end
    endtask

    task automatic test_reset();
        do_reset();
        nchk++;
        if ({rd_data, rd_valid, rd_ch, rd_last, busy, triggered, done, trig_addr} !== '0) begin
            nerr++;
            $display("FAIL reset outputs: data=%h vld=%0b ch=%0d last=%0b busy=%0b trig=%0b done=%0b taddr=%0d want all 0",
                     rd_data, rd_valid, rd_ch, rd_last, busy, triggered, done, trig_addr);
        end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        nchk++;
        if (rd_valid !== 1'b0) begin nerr++; $display("FAIL idle read: rd_valid=%0b want 0", rd_valid); end
    endtask

    task automatic test_sw_basic();
        do_reset();
        do_arm(4'd4, 2'd0, 2'd0, '0);
        nchk++;
        if (busy !== 1'b1) begin nerr++; $display("FAIL basic busy after arm: %0b want 1", busy); end
        for (int f = 0; f <= 21; f++) begin
            send(ramp(f), f == 10, 1'b1);
            if (f == 9) begin
                nchk++;
                if (triggered !== 1'b0) begin nerr++; $display("FAIL basic early trig: %0b want 0", triggered); end
            end
            if (f == 10) begin
                nchk++;
                if (triggered !== 1'b1 || trig_addr !== 4'd10) begin
                    nerr++; $display("FAIL basic trig: trig=%0b addr=%0d want 1/10", triggered, trig_addr);
                end
            end
            if (f == 20 || f == 21) begin
                nchk++;
                if (done !== (f == 21) || busy !== (f != 21)) begin
                    nerr++; $display("FAIL basic done at frame %0d: done=%0b busy=%0b", f, done, busy);
                end
            end
        end
        send(ramp(60), 1'b0, 1'b0);
        send(ramp(61), 1'b0, 1'b0);
        read_record("basic", 10, 4, NUM_CH * DEPTH);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        nchk++;
        if (rd_valid !== 1'b0 || done !== 1'b1) begin
            nerr++; $display("FAIL read past end: vld=%0b done=%0b want 0/1", rd_valid, done);
        end
    endtask

    task automatic test_threshold();
        do_reset();
        do_arm('0, 2'd1, 2'd2, 12'h800);
        send(mkf(12'h7F0, 12'h000), 1'b0, 1'b1);
        send(mkf(12'h7F8, 12'h900), 1'b0, 1'b1);
        nchk++;
        if (triggered !== 1'b0) begin nerr++; $display("FAIL rise early: trig=%0b want 0", triggered); end
        send(mkf(12'h800, 12'h900), 1'b0, 1'b1);
        nchk++;
        if (triggered !== 1'b1 || trig_addr !== 4'd2) begin
            nerr++; $display("FAIL rise fire: trig=%0b addr=%0d want 1/2", triggered, trig_addr);
        end
        do_arm('0, 2'd1, 2'd2, 12'h800);
        nchk++;
        if (triggered !== 1'b0) begin nerr++; $display("FAIL rearm clear: trig=%0b want 0", triggered); end
        send(mkf(12'h800, 12'h000), 1'b0, 1'b1);
        send(mkf(12'h800, 12'h000), 1'b0, 1'b1);
        send(mkf(12'h810, 12'h000), 1'b0, 1'b1);
        send(mkf(12'h800, 12'h000), 1'b0, 1'b1);
        nchk++;
        if (triggered !== 1'b0) begin nerr++; $display("FAIL rise repeat/step: trig=%0b want 0", triggered); end
        send(mkf(12'h000, 12'h000), 1'b1, 1'b1);
        nchk++;
        if (triggered !== 1'b1 || trig_addr !== 4'd7) begin
            nerr++; $display("FAIL sw in rise mode: trig=%0b addr=%0d want 1/7", triggered, trig_addr);
        end
        do_arm('0, 2'd2, 2'd2, 12'h800);
        send(mkf(12'h810, 12'h000), 1'b0, 1'b1);
        nchk++;
        if (triggered !== 1'b0) begin nerr++; $display("FAIL fall early: trig=%0b want 0", triggered); end
        send(mkf(12'h800, 12'hFFF), 1'b0, 1'b1);
        nchk++;
        if (triggered !== 1'b1 || trig_addr !== 4'd9) begin
            nerr++; $display("FAIL fall fire: trig=%0b addr=%0d want 1/9", triggered, trig_addr);
        end
    endtask

    task automatic test_fill_ignore();
        do_reset();
        do_arm(4'd8, 2'd0, 2'd0, '0);
        for (int f = 0; f <= 8; f++) send(ramp(f), (f == 2) || (f == 7), 1'b1);
        nchk++;
        if (triggered !== 1'b0) begin nerr++; $display("FAIL fill sw ignored: trig=%0b want 0", triggered); end
        sw_trig = 1'b1; tick(); sw_trig = 1'b0;
        nchk++;
        if (triggered !== 1'b0) begin nerr++; $display("FAIL pending w/o frame: trig=%0b want 0", triggered); end
        send(ramp(9), 1'b0, 1'b1);
        nchk++;
        if (triggered !== 1'b1 || trig_addr !== 4'd9) begin
            nerr++; $display("FAIL pending fire: trig=%0b addr=%0d want 1/9", triggered, trig_addr);
        end
        for (int f = 10; f <= 16; f++) begin
            send(ramp(f), 1'b0, 1'b1);
            if (f >= 15) begin
                nchk++;
                if (done !== (f == 16)) begin nerr++; $display("FAIL fill done at %0d: %0b", f, done); end
            end
        end
        read_record("fill", 9, 8, NUM_CH * DEPTH);
    endtask

    task automatic test_p0_p15();
        do_reset();
        do_arm('0, 2'd0, 2'd0, '0);
        send(ramp(0), 1'b1, 1'b1);
        nchk++;
        if (triggered !== 1'b1 || trig_addr !== 4'd0) begin
            nerr++; $display("FAIL p0 trig: trig=%0b addr=%0d want 1/0", triggered, trig_addr);
        end
        for (int f = 1; f <= 15; f++) send(ramp(f), 1'b0, 1'b1);
        nchk++;
        if (done !== 1'b1) begin nerr++; $display("FAIL p0 done: %0b want 1", done); end
        read_record("p0", 0, 0, 8);
        rd_en = 1'b1; arm = 1'b1; pre_samples = 4'd15; trig_mode = 2'd0;
        tick();
        rd_en = 1'b0; arm = 1'b0;
        nchk++;
        if (rd_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            nerr++; $display("FAIL arm cancels read: vld=%0b busy=%0b done=%0b want 0/1/0", rd_valid, busy, done);
        end
        for (int f = 16; f <= 30; f++) send(ramp(f), 1'b0, 1'b1);
        nchk++;
        if (triggered !== 1'b0 || busy !== 1'b1) begin
            nerr++; $display("FAIL p15 pre: trig=%0b busy=%0b want 0/1", triggered, busy);
        end
        send(ramp(31), 1'b1, 1'b1);
        nchk++;
        if (done !== 1'b1 || triggered !== 1'b1 || trig_addr !== 4'd15) begin
            nerr++; $display("FAIL p15 immediate done: done=%0b trig=%0b addr=%0d want 1/1/15", done, triggered, trig_addr);
        end
        read_record("p15", 31, 15, NUM_CH * DEPTH);
    endtask

    task automatic test_wrap();
        do_reset();
        do_arm(4'd4, 2'd0, 2'd0, '0);
        for (int f = 0; f <= 51; f++) send(ramp(f), f == 40, 1'b1);
        nchk++;
        if (done !== 1'b1 || trig_addr !== 4'd8) begin
            nerr++; $display("FAIL wrap: done=%0b addr=%0d want 1/8", done, trig_addr);
        end
        read_record("wrap", 40, 4, NUM_CH * DEPTH);
    endtask

    task automatic test_async_reset();
        do_reset();
        do_arm(4'd4, 2'd0, 2'd0, '0);
        for (int f = 0; f <= 9; f++) send(ramp(f), f == 6, 1'b1);
        nchk++;
        if (busy !== 1'b1 || triggered !== 1'b1) begin
            nerr++; $display("FAIL pre-reset POST: busy=%0b trig=%0b want 1/1", busy, triggered);
        end
        #2 rstn = 1'b0;
        #1;
        nchk++;
        if ({rd_data, rd_valid, rd_ch, rd_last, busy, triggered, done, trig_addr} !== '0) begin
            nerr++;
            $display("FAIL async reset: busy=%0b trig=%0b done=%0b taddr=%0d vld=%0b want all 0",
                     busy, triggered, done, trig_addr, rd_valid);
        end
        tick();
        rstn = 1'b1;
        gidx = 0;
        arm = 1'b1; pre_samples = 4'd2; trig_mode = 2'd0;
        sample_valid = 1'b1; sample_data = ramp(0);
        tick();
        arm = 1'b0; sample_valid = 1'b0;
        flog[0] = ramp(0);
        gidx = 1;
        send(ramp(1), 1'b0, 1'b1);
        send(ramp(2), 1'b1, 1'b1);
        nchk++;
        if (triggered !== 1'b1 || trig_addr !== 4'd2) begin
            nerr++; $display("FAIL arm+frame count: trig=%0b addr=%0d want 1/2", triggered, trig_addr);
        end
        for (int f = 3; f <= 15; f++) send(ramp(f), 1'b0, 1'b1);
        nchk++;
        if (done !== 1'b1) begin nerr++; $display("FAIL post-reset done: %0b want 1", done); end
        read_record("rst", 2, 2, NUM_CH * DEPTH);
    endtask

    initial begin
        test_reset();
        test_sw_basic();
        test_threshold();
        test_fill_ignore();
        test_p0_p15();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
